ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
AHB-Lite responder: the slave end that each master port of the arbitration switch is routed to. It accepts pipelined address/data-phase transfers into a local word-addressed SRAM. It inserts a parameterised number of wait states, returns a two-cycle ERROR for illegal accesses, and pulses slave_done when a transfer sequence finishes. The switch uses slave_done to clear its ongoing flag and re-arbitrate.

Parameters:
ADDR_W, 12, byte-address width of HADDR
DEPTH, 1024, number of 32-bit words; legal word index 0..DEPTH-1
WAIT_STATES, 1, HREADYOUT-low cycles inserted before each OKAY data phase (0..15)

Ports:
HCLK  input  1  clock, all state on rising edge
HRESET  input  1  reset; one clock; reset is synchronous and active-high
HSEL  input  1  slave select
HADDR  input  ADDR_W  byte address (address phase)
HWRITE  input  1  1=write, 0=read (address phase)
HSIZE  input  3  0=byte, 1=half, 2=word; others illegal
HTRANS  input  2 (HTRANS_state)  IDLE/BUSY/NONSEQ/SEQ
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus-level ready from switch
HREADYOUT  output  1  slave ready
HRESP  output  1  0=OKAY, 1=ERROR
HRDATA  output  32  read data
slave_done  output  1  one-cycle end-of-sequence pulse

Behaviour:
- Reset (HRESET=1 at edge): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, slave_done=0, wait counter=0. SRAM contents not reset. Reset mid-data-phase aborts it; no write commits.
- Address sample: at an edge with HSEL=1, HREADY=1, and HTRANS in {NONSEQ,SEQ}, capture HADDR, HWRITE, HSIZE. IDLE/BUSY, or HSEL=0 -> no transfer, zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Legality check at sample: illegal if HSIZE>2, misaligned (half: HADDR[0]=1; word: HADDR[1:0]!=0), or HADDR[ADDR_W-1:2]>=DEPTH.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE/DATA/ERR2 + legal sample -> WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES), else DATA.
  - IDLE/DATA/ERR2 + illegal sample -> ERR1.
  - IDLE/DATA/ERR2 + no sample -> IDLE.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle; at counter==1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; data phase completes this cycle.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
- Address samples are accepted only while HREADYOUT=1 (HREADY=1). A pipelined next address captured at the completing edge of DATA/ERR2 starts its own data phase immediately (back-to-back).
- Write: commits at the edge ending DATA. Byte lanes are little-endian per addr[1:0] and HSIZE. Unselected lanes are unchanged. Never commits from ERR1/ERR2.
- Read: HRDATA = full 32-bit word mem[addr_q] in DATA when HWRITE_q=0; 0 otherwise. A read whose data phase follows a write to the same word returns the post-write value.
- slave_done: high for one cycle, the cycle after a data phase completes (DATA or ERR2) with no new address sampled at that edge. Back-to-back transfers produce a single pulse at the end of the sequence. Never asserted in reset.
- HTRANS=BUSY mid-burst terminates nothing. It is a non-sample, so the sequence ends as above.

Test Plan:
1. WAIT_STATES=1, NONSEQ word write 0x00000010, HWDATA=0xDEADBEEF, then IDLE -> HREADYOUT 0 for 1 cycle then 1; mem[4]=0xDEADBEEF; slave_done pulses once the next cycle.
2. Same address read after test 1 -> HRDATA=0xDEADBEEF in DATA cycle, HRESP=0; byte write 0xAA at 0x12 then word read -> 0xDEAABEEF.
3. WAIT_STATES=0, 4-beat burst NONSEQ+3xSEQ write to 0x20..0x2C, data 1..4 -> HREADYOUT stays 1; mem[8..11]=1..4; exactly one slave_done pulse, after beat 4.
4. Word write to 0x11 (misaligned), and read of 0x1000 (DEPTH=1024) -> each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; memory unchanged; slave_done after ERR2.
5. WAIT_STATES=3, assert HRESET during 2nd wait cycle of a write -> next cycle HREADYOUT=1, HRESP=0, slave_done=0; target word unchanged.
6. HSEL=0 or HREADY=0 with HTRANS=NONSEQ -> no sample; FSM stays IDLE, no memory change, no slave_done.

Source files
------------

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between the arbitration switch (master side) and an SRAM responder.
interface ahb_lite_sram_slave_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [1:0]        HTRANS;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic              slave_done;

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA, slave_done
  );

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA, slave_done
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: pipelined address/data phases, fixed wait states before each OKAY
// data phase, two-cycle ERROR for illegal accesses, and an end-of-sequence slave_done pulse.
module ahb_lite_sram_slave #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_lite_sram_slave_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [31:0]       mem_q [DEPTH];

  logic        hreadyout;
  logic        sample;
  logic        legal;
  logic [3:0]  be;
  logic [AW-1:0] widx;

  assign widx = addr_q[AW+1:2];

  // Bus-facing ready/response and address-phase qualification.
  always_comb begin
    hreadyout = !((state_q == StWait) || (state_q == StErr1));
    sample    = bus.HSEL && bus.HREADY && hreadyout &&
                ((bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11));
    legal     = 1'b1;
    if (bus.HSIZE > 3'd2) legal = 1'b0;
    if ((bus.HSIZE == 3'd1) && bus.HADDR[0]) legal = 1'b0;
    if ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00)) legal = 1'b0;
    if (32'(bus.HADDR[ADDR_W-1:2]) >= DEPTH) legal = 1'b0;
  end

  // Next-state logic; slave_done is registered so it lands the cycle after completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StData;
      end
      StErr1: state_d = StErr2;
      default: begin
        // IDLE, DATA and ERR2 all accept a new address phase.
        if (sample) begin
          if (!legal) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = StData;
          end
        end else begin
          state_d = StIdle;
        end
        done_d = ((state_q == StData) || (state_q == StErr2)) && !sample;
      end
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (sample) begin
        addr_q  <= bus.HADDR;
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE;
      end
    end
  end

  // Little-endian byte-lane enables from the captured address and size.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // SRAM write port: commits at the edge that ends DATA; reset aborts the commit.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == StData) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADYOUT  = hreadyout;
  assign bus.HRESP      = (state_q == StErr1) || (state_q == StErr2);
  assign bus.HRDATA     = ((state_q == StData) && !write_q) ? mem_q[widx] : 32'h0;
  assign bus.slave_done = done_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: three responders (0, 1 and 3 wait states) share one stimulus bus; only the
// active one is selected, and its outputs are compared with hand-computed values.
module tb_ahb_lite_sram_slave;

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic [12:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] hwdata = '0;
  logic        hready_en = 1'b1;
  int          active = 1;

  logic        hreadyout, hresp, slave_done;
  logic [31:0] hrdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahb_lite_sram_slave_if #(.ADDR_W(13)) bus0 ();
  ahb_lite_sram_slave_if #(.ADDR_W(13)) bus1 ();
  ahb_lite_sram_slave_if #(.ADDR_W(13)) bus2 ();

  assign bus0.HSEL = hsel && (active == 0);
  assign bus1.HSEL = hsel && (active == 1);
  assign bus2.HSEL = hsel && (active == 2);
  assign bus0.HADDR = haddr;
  assign bus1.HADDR = haddr;
  assign bus2.HADDR = haddr;
  assign bus0.HWRITE = hwrite;
  assign bus1.HWRITE = hwrite;
  assign bus2.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;
  assign bus1.HSIZE = hsize;
  assign bus2.HSIZE = hsize;
  assign bus0.HTRANS = htrans;
  assign bus1.HTRANS = htrans;
  assign bus2.HTRANS = htrans;
  assign bus0.HWDATA = hwdata;
  assign bus1.HWDATA = hwdata;
  assign bus2.HWDATA = hwdata;
  assign bus0.HREADY = hready_en && bus0.HREADYOUT;
  assign bus1.HREADY = hready_en && bus1.HREADYOUT;
  assign bus2.HREADY = hready_en && bus2.HREADYOUT;

  ahb_lite_sram_slave #(.ADDR_W(13), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(hreset), .bus(bus0.slave)
  );
  ahb_lite_sram_slave #(.ADDR_W(13), .DEPTH(1024), .WAIT_STATES(1)) u_ws1 (
    .HCLK(clk), .HRESET(hreset), .bus(bus1.slave)
  );
  ahb_lite_sram_slave #(.ADDR_W(13), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESET(hreset), .bus(bus2.slave)
  );

  always_comb begin
    hreadyout  = bus1.HREADYOUT;
    hresp      = bus1.HRESP;
    hrdata     = bus1.HRDATA;
    slave_done = bus1.slave_done;
    case (active)
      0: begin
        hreadyout = bus0.HREADYOUT; hresp = bus0.HRESP;
        hrdata = bus0.HRDATA; slave_done = bus0.slave_done;
      end
      2: begin
        hreadyout = bus2.HREADYOUT; hresp = bus2.HRESP;
        hrdata = bus2.HRDATA; slave_done = bus2.slave_done;
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One NONSEQ transfer followed by IDLE; reports response, wait count and the done pulse.
  task automatic xfer(input logic wr, input logic [12:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rsp0,
                      output logic rsp, output int nwait, output logic done);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    rsp0  = hresp;
    nwait = 0;
    while (hreadyout !== 1'b1 && nwait < 20) begin
      tick();
      nwait++;
    end
    rd  = hrdata;
    rsp = hresp;
    tick();
    done = slave_done;
  endtask

  logic [31:0] rd;
  logic        rsp0, rsp, done;
  int          nw;
  int          ndone;

  initial begin
    // Reset state.
    tick(); tick();
    hreset = 1'b0;
    check_eq("rst_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("rst_hresp", 32'(hresp), 32'd0);
    check_eq("rst_hrdata", hrdata, 32'h0);
    check_eq("rst_done", 32'(slave_done), 32'd0);

    // 1: one wait state, word write.
    active = 1;
    xfer(1'b1, 13'h010, 3'd2, 32'hDEADBEEF, rd, rsp0, rsp, nw, done);
    check_eq("t1_nwait", 32'(nw), 32'd1);
    check_eq("t1_resp", 32'(rsp), 32'd0);
    check_eq("t1_done", 32'(done), 32'd1);
    tick();
    check_eq("t1_done_fall", 32'(slave_done), 32'd0);

    // 2: read back, byte write, read merged word.
    xfer(1'b0, 13'h010, 3'd2, 32'h0, rd, rsp0, rsp, nw, done);
    check_eq("t2_rdata", rd, 32'hDEADBEEF);
    check_eq("t2_resp", 32'(rsp), 32'd0);
    check_eq("t2_done", 32'(done), 32'd1);
    xfer(1'b1, 13'h012, 3'd0, 32'h00AA0000, rd, rsp0, rsp, nw, done);
    xfer(1'b0, 13'h010, 3'd2, 32'h0, rd, rsp0, rsp, nw, done);
    check_eq("t2_merged", rd, 32'hDEAABEEF);
    xfer(1'b1, 13'h016, 3'd1, 32'h5A5A0000, rd, rsp0, rsp, nw, done);
    xfer(1'b0, 13'h014, 3'd2, 32'h0, rd, rsp0, rsp, nw, done);
    check_eq("t2_half_hi", rd[31:16], 32'h5A5A);

    // 3: zero wait states, 4-beat burst write.
    active = 0;
    ndone = 0;
    hsel = 1'b1; htrans = 2'b10; haddr = 13'h020; hwrite = 1'b1; hsize = 3'd2;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_ready_b%0d", i), 32'(hreadyout), 32'd1);
      if (slave_done) ndone++;
      hwdata = 32'(i + 1);
      if (i < 3) begin
        htrans = 2'b11; haddr = 13'(13'h024 + 13'(4 * i));
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      tick();
    end
    check_eq("t3_done", 32'(slave_done), 32'd1);
    tick();
    check_eq("t3_done_fall", 32'(slave_done), 32'd0);
    check_eq("t3_early_done", 32'(ndone), 32'd0);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 13'(13'h020 + 13'(4 * i)), 3'd2, 32'h0, rd, rsp0, rsp, nw, done);
      check_eq($sformatf("t3_mem%0d", 8 + i), rd, 32'(i + 1));
      if (i == 0) check_eq("t3_read_nwait", 32'(nw), 32'd0);
    end

    // 4: illegal accesses give two-cycle ERROR and leave memory alone.
    active = 1;
    xfer(1'b1, 13'h010, 3'd2, 32'h12345678, rd, rsp0, rsp, nw, done);
    xfer(1'b1, 13'h011, 3'd2, 32'hFFFFFFFF, rd, rsp0, rsp, nw, done);
    check_eq("t4a_err1", 32'(rsp0), 32'd1);
    check_eq("t4a_nwait", 32'(nw), 32'd1);
    check_eq("t4a_err2", 32'(rsp), 32'd1);
    check_eq("t4a_done", 32'(done), 32'd1);
    xfer(1'b0, 13'h1000, 3'd2, 32'h0, rd, rsp0, rsp, nw, done);
    check_eq("t4b_err1", 32'(rsp0), 32'd1);
    check_eq("t4b_nwait", 32'(nw), 32'd1);
    check_eq("t4b_err2", 32'(rsp), 32'd1);
    check_eq("t4b_rdata", rd, 32'h0);
    check_eq("t4b_done", 32'(done), 32'd1);
    xfer(1'b0, 13'h010, 3'd2, 32'h0, rd, rsp0, rsp, nw, done);
    check_eq("t4_mem_kept", rd, 32'h12345678);
    check_eq("t4_ok_resp", 32'(rsp), 32'd0);

    // 5: three wait states, reset during second wait cycle of a write.
    active = 2;
    xfer(1'b1, 13'h030, 3'd2, 32'hCAFEF00D, rd, rsp0, rsp, nw, done);
    check_eq("t5_nwait", 32'(nw), 32'd3);
    hsel = 1'b1; htrans = 2'b10; haddr = 13'h030; hwrite = 1'b1; hsize = 3'd2;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    check_eq("t5_wait1", 32'(hreadyout), 32'd0);
    tick();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    check_eq("t5_rst_ready", 32'(hreadyout), 32'd1);
    check_eq("t5_rst_resp", 32'(hresp), 32'd0);
    check_eq("t5_rst_done", 32'(slave_done), 32'd0);
    tick();
    check_eq("t5_rst_done2", 32'(slave_done), 32'd0);
    xfer(1'b0, 13'h030, 3'd2, 32'h0, rd, rsp0, rsp, nw, done);
    check_eq("t5_mem_kept", rd, 32'hCAFEF00D);

    // 6: no sample with HSEL low or HREADY low.
    active = 1;
    hsel = 1'b0; htrans = 2'b10; haddr = 13'h010; hwrite = 1'b1; hsize = 3'd2;
    hwdata = 32'h0;
    tick();
    check_eq("t6a_ready", 32'(hreadyout), 32'd1);
    tick();
    check_eq("t6a_done", 32'(slave_done), 32'd0);
    hsel = 1'b1; hready_en = 1'b0;
    tick();
    check_eq("t6b_ready", 32'(hreadyout), 32'd1);
    tick();
    check_eq("t6b_done", 32'(slave_done), 32'd0);
    hsel = 1'b0; htrans = 2'b00; hready_en = 1'b1;
    tick();
    xfer(1'b0, 13'h010, 3'd2, 32'h0, rd, rsp0, rsp, nw, done);
    check_eq("t6_mem_kept", rd, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
